enemy_event_arbiter: RTL



---
 rtl/enemy_event_pkg.sv | 19 +
 rtl/enemy_event_arbiter_if.sv | 44 ++++
 rtl/frame_cooldown.sv | 33 +++
 rtl/enemy_event_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/enemy_event_pkg.sv
// Shared types and constants for the enemy event arbiter slice.
// Optional statistics counters are enabled by ENEMY_EVENT_STATS_EN.
package enemy_event_pkg;

  typedef enum logic [1:0] {
    ENEMY_ST_ACTIVE = 2'd0,
    ENEMY_ST_HIT    = 2'd1,
    ENEMY_ST_DEAD   = 2'd2
  } enemyStateT;

  localparam int unsigned DODGE_WAIT_DEF = 35;
  localparam int unsigned NUM_SHOTS_DEF  = 3;
  localparam int unsigned COOLDOWN_W     = 6;

  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/enemy_event_arbiter_if.sv
// Pixel-request inputs and enemy event outputs of one enemy instance.
// hitCount/dodgeCount exist only when ENEMY_EVENT_STATS_EN is defined.
interface enemy_event_arbiter_if
  import enemy_event_pkg::*;
#(
  parameter int unsigned NUM_SHOTS = NUM_SHOTS_DEF
);
  logic                 startOfFrame;
  logic                 enemyDrawingRequest;
  logic                 towerDrawingRequest;
  logic                 dangerZoneRequest;
  logic [NUM_SHOTS-1:0] shotDrawingRequest;
  logic                 pauseKey;
  logic                 respawn;
  logic                 changeDirection;
  logic                 dodgeBullet;
  logic [NUM_SHOTS-1:0] shotCollision;
  logic                 pause;
  logic                 enemyAlive;
`ifdef ENEMY_EVENT_STATS_EN
  logic [7:0]           hitCount;
  logic [7:0]           dodgeCount;
`endif

  // Arbiter side: consumes pixel requests, produces events.
  modport master (
    input  startOfFrame, enemyDrawingRequest, towerDrawingRequest, dangerZoneRequest,
    input  shotDrawingRequest, pauseKey, respawn,
`ifdef ENEMY_EVENT_STATS_EN
    output hitCount, dodgeCount,
`endif
    output changeDirection, dodgeBullet, shotCollision, pause, enemyAlive
  );

  modport slave (
    output startOfFrame, enemyDrawingRequest, towerDrawingRequest, dangerZoneRequest,
    output shotDrawingRequest, pauseKey, respawn,
`ifdef ENEMY_EVENT_STATS_EN
    input  hitCount, dodgeCount,
`endif
    input  changeDirection, dodgeBullet, shotCollision, pause, enemyAlive
  );

endinterface

// File: rtl/frame_cooldown.sv
// Frame-based cooldown: loads a frame count, decrements once per frame tick,
// saturates at zero; busy while nonzero. Fully held while frozen.
module frame_cooldown
  import enemy_event_pkg::*;
#(
  parameter int unsigned WIDTH = COOLDOWN_W
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             tick,
  input  logic             freeze,
  output logic             busy
);

  logic [WIDTH-1:0] countQ;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      countQ <= '0;
    end else if (!freeze) begin
      if (load) begin
        countQ <= loadValue;
      end else if (tick && (countQ != '0)) begin
        countQ <= countQ - WIDTH'(1);
      end
    end
  end

  assign busy = (countQ != '0);

endmodule

// File: rtl/enemy_event_arbiter.sv
// Turns per-pixel overlaps into rate-limited enemy events (one instance per enemy).
// Define ENEMY_EVENT_STATS_EN to add saturating hitCount/dodgeCount outputs.
module enemy_event_arbiter
  import enemy_event_pkg::*;
#(
  parameter int unsigned DODGE_WAIT = DODGE_WAIT_DEF,
  parameter int unsigned NUM_SHOTS  = NUM_SHOTS_DEF
) (
  input logic                   clk,
  input logic                   resetN,
  enemy_event_arbiter_if.master bus
);

  enemyStateT           stateQ;
  logic                 pauseKeyQ;
  logic                 pauseQ;
  logic                 towerFlagQ;
  logic                 dangerFlagQ;
  logic                 changeDirectionQ;
  logic                 dodgeBulletQ;
  logic                 enemyAliveQ;
  logic [NUM_SHOTS-1:0] shotCollisionQ;

  logic [NUM_SHOTS-1:0] shotOverlap;
  logic                 towerOverlap;
  logic                 dangerOverlap;
  logic                 isActive;
  logic                 hit;
  logic                 towerSeen;
  logic                 dangerSeen;
  logic                 fireTower;
  logic                 fireDodge;
  logic                 cooldownBusy;

  always_comb begin
    towerOverlap  = bus.enemyDrawingRequest & bus.towerDrawingRequest;
    dangerOverlap = bus.enemyDrawingRequest & bus.dangerZoneRequest;
    shotOverlap   = bus.shotDrawingRequest & {NUM_SHOTS{bus.enemyDrawingRequest}};
    isActive      = (stateQ == ENEMY_ST_ACTIVE) && !pauseQ;
    hit           = isActive && (|shotOverlap);
    // Frame start clears the flags before this pixel is judged.
    towerSeen     = towerFlagQ && !bus.startOfFrame;
    dangerSeen    = dangerFlagQ && !bus.startOfFrame;
    fireTower     = isActive && !hit && towerOverlap && !towerSeen;
    fireDodge     = isActive && !hit && dangerOverlap && !dangerSeen && !cooldownBusy;
  end

  frame_cooldown #(
    .WIDTH(COOLDOWN_W)
  ) u_dodge_cooldown (
    .clk      (clk),
    .resetN   (resetN),
    .load     (fireDodge),
    .loadValue(COOLDOWN_W'(DODGE_WAIT)),
    .tick     (bus.startOfFrame),
    .freeze   (pauseQ),
    .busy     (cooldownBusy)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stateQ           <= ENEMY_ST_ACTIVE;
      pauseKeyQ        <= 1'b0;
      pauseQ           <= 1'b0;
      towerFlagQ       <= 1'b0;
      dangerFlagQ      <= 1'b0;
      changeDirectionQ <= 1'b0;
      dodgeBulletQ     <= 1'b0;
      enemyAliveQ      <= 1'b1;
      shotCollisionQ   <= '0;
    end else begin
      pauseKeyQ        <= bus.pauseKey;
      if (bus.pauseKey && !pauseKeyQ) begin
        pauseQ <= !pauseQ;
      end
      changeDirectionQ <= fireTower;
      dodgeBulletQ     <= fireDodge;
      shotCollisionQ   <= hit ? shotOverlap : '0;
      // Pause freezes the flags and every state transition, HIT included.
      if (!pauseQ) begin
        towerFlagQ  <= towerSeen | fireTower | hit;
        dangerFlagQ <= dangerSeen | fireDodge | hit;
        unique case (stateQ)
          ENEMY_ST_ACTIVE: begin
            if (hit) begin
              stateQ      <= ENEMY_ST_HIT;
              enemyAliveQ <= 1'b0;
            end
          end
          ENEMY_ST_HIT: begin
            stateQ <= ENEMY_ST_DEAD;
          end
          ENEMY_ST_DEAD: begin
            if (bus.respawn) begin
              stateQ      <= ENEMY_ST_ACTIVE;
              enemyAliveQ <= 1'b1;
            end
          end
          default: begin
            stateQ      <= ENEMY_ST_ACTIVE;
            enemyAliveQ <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.changeDirection = changeDirectionQ;
  assign bus.dodgeBullet     = dodgeBulletQ;
  assign bus.shotCollision   = shotCollisionQ;
  assign bus.pause           = pauseQ;
  assign bus.enemyAlive      = enemyAliveQ;

`ifdef ENEMY_EVENT_STATS_EN
  logic [7:0] hitCountQ;
  logic [7:0] dodgeCountQ;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hitCountQ   <= '0;
      dodgeCountQ <= '0;
    end else begin
      if (|shotCollisionQ) begin
        hitCountQ <= satInc8(hitCountQ);
      end
      if (dodgeBulletQ) begin
        dodgeCountQ <= satInc8(dodgeCountQ);
      end
    end
  end

  assign bus.hitCount   = hitCountQ;
  assign bus.dodgeCount = dodgeCountQ;
`endif

endmodule
